// File: rtl/cv32e40p_tmr_spare_mgr.sv
// cv32e40p_tmr_spare_mgr
// Bitwise 2-of-3 majority voter with per-slot mismatch accounting and
// hot-spare substitution. Build option CV32E40P_TMR_SPARE_EN enables the spare
// and the SPARED state. Without it, spare_i is ignored and the spare outputs
// are tied low. In that build a faulty slot keeps voting, and the block
// degrades once two slots are flagged.
// FSM state is visible on the ports: spare_active_o marks SPARED and fatal_o
// marks DEGRADED.
module cv32e40p_tmr_spare_mgr #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned THRESHOLD = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] rep0_i,
    input  logic [WIDTH-1:0] rep1_i,
    input  logic [WIDTH-1:0] rep2_i,
    input  logic [WIDTH-1:0] spare_i,
    output logic [WIDTH-1:0] data_o,
    output logic             error_o,
    output logic [2:0]       mismatch_o,
    output logic             uncorr_o,
    output logic [2:0]       faulty_o,
    output logic             spare_active_o,
    output logic [1:0]       spare_slot_o,
    output logic             fatal_o
);

    typedef enum logic [1:0] {
        ST_NOMINAL  = 2'd0,
        ST_SPARED   = 2'd1,
        ST_DEGRADED = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       faulty_q, faulty_d;

    logic [WIDTH-1:0] slot [3];
    logic [WIDTH-1:0] vote;
    logic [2:0]       mismatch;
    logic             uncorr;
    logic [2:0]       spare_here;
    logic [2:0]       count_en;
    logic [2:0]       hit;
    logic [1:0]       n_hits;
    logic [1:0]       n_faulty;

`ifdef CV32E40P_TMR_SPARE_EN
    logic       spare_active_q, spare_active_d;
    logic [1:0] spare_slot_q, spare_slot_d;

    assign spare_active_o = spare_active_q;
    assign spare_slot_o   = spare_slot_q;

    // Which slot (if any) is currently fed by the spare replica.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            spare_here[k] = spare_active_q && (spare_slot_q == 2'(k));
        end
    end
`else
    logic unused_spare;

    assign unused_spare   = ^spare_i;
    assign spare_active_o = 1'b0;
    assign spare_slot_o   = 2'd0;
    assign spare_here     = 3'b000;
`endif

    // Slot multiplexing and zero-latency bitwise majority vote.
    always_comb begin
        slot[0] = rep0_i;
        slot[1] = rep1_i;
        slot[2] = rep2_i;
`ifdef CV32E40P_TMR_SPARE_EN
        for (int k = 0; k < 3; k++) begin
            if (spare_here[k]) slot[k] = spare_i;
        end
`endif
        vote = (slot[0] & slot[1]) | (slot[0] & slot[2]) | (slot[1] & slot[2]);
        for (int k = 0; k < 3; k++) begin
            mismatch[k] = (slot[k] != vote);
        end
        uncorr = (slot[0] != slot[1]) && (slot[0] != slot[2]) && (slot[1] != slot[2]);
    end

    assign data_o     = vote;
    assign mismatch_o = mismatch;
    assign error_o    = |mismatch;
    assign uncorr_o   = uncorr;
    assign faulty_o   = faulty_q;
    assign fatal_o    = (state_q == ST_DEGRADED);

    // Decide which counters advance and which slots reach the threshold.
    // The spare-fed slot keeps counting although its faulty bit flags the
    // replaced replica.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            count_en[k] = valid_i && mismatch[k] && !uncorr &&
                          (state_q != ST_DEGRADED) &&
                          (!faulty_q[k] || spare_here[k]) &&
                          (cnt_q[k] != THR);
            hit[k]      = count_en[k] && (cnt_q[k] == THR_M1);
        end
        n_hits = {1'b0, hit[0]} + {1'b0, hit[1]} + {1'b0, hit[2]};
    end

    // Next-state logic: counters, fault flags, spare mapping and FSM.
    always_comb begin
        state_d  = state_q;
        faulty_d = faulty_q;
        n_faulty = 2'd0;
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = count_en[k] ? cnt_q[k] + CNT_W'(1) : cnt_q[k];
        end
`ifdef CV32E40P_TMR_SPARE_EN
        spare_active_d = spare_active_q;
        spare_slot_d   = spare_slot_q;
        case (state_q)
            ST_NOMINAL: begin
                if (n_hits == 2'd1) begin
                    state_d        = ST_SPARED;
                    spare_active_d = 1'b1;
                    faulty_d       = faulty_q | hit;
                    for (int k = 0; k < 3; k++) begin
                        if (hit[k]) begin
                            spare_slot_d = 2'(k);
                            cnt_d[k]     = '0;
                        end
                    end
                end else if (n_hits != 2'd0) begin
                    state_d  = ST_DEGRADED;
                    faulty_d = faulty_q | hit;
                end
            end
            ST_SPARED: begin
                if (|hit) begin
                    state_d  = ST_DEGRADED;
                    faulty_d = faulty_q | hit;
                end
            end
            ST_DEGRADED: begin
                state_d = ST_DEGRADED;
            end
            default: begin
                state_d = ST_NOMINAL;
            end
        endcase
`else
        faulty_d = faulty_q | hit;
        n_faulty = {1'b0, faulty_d[0]} + {1'b0, faulty_d[1]} + {1'b0, faulty_d[2]};
        if (n_faulty >= 2'd2) state_d = ST_DEGRADED;
`endif
        if (clear_i) begin
            state_d  = ST_NOMINAL;
            faulty_d = 3'b000;
            for (int k = 0; k < 3; k++) cnt_d[k] = '0;
`ifdef CV32E40P_TMR_SPARE_EN
            spare_active_d = 1'b0;
            spare_slot_d   = 2'd0;
`endif
        end
    end

    // State registers with asynchronous reset (mapping drops immediately).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_NOMINAL;
            faulty_q <= 3'b000;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
`ifdef CV32E40P_TMR_SPARE_EN
            spare_active_q <= 1'b0;
            spare_slot_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            faulty_q <= faulty_d;
            for (int k = 0; k < 3; k++) cnt_q[k] <= cnt_d[k];
`ifdef CV32E40P_TMR_SPARE_EN
            spare_active_q <= spare_active_d;
            spare_slot_q   <= spare_slot_d;
`endif
        end
    end

endmodule

// File: tb/tb_cv32e40p_tmr_spare_mgr.sv
// Directed bench for cv32e40p_tmr_spare_mgr (WIDTH=32, THRESHOLD=3).
// The spare-substitution sequence runs when CV32E40P_TMR_SPARE_EN is defined;
// otherwise the no-spare sequence runs.
module tb_cv32e40p_tmr_spare_mgr;

    localparam int W = 32;
    localparam int T = 3;
    localparam int C = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         clear;
    logic [W-1:0] r0, r1, r2, sp;
    logic [W-1:0] data;
    logic         error;
    logic [2:0]   mismatch;
    logic         uncorr;
    logic [2:0]   faulty;
    logic         spare_active;
    logic [1:0]   spare_slot;
    logic         fatal;

    int vectors     = 0;
    int miscompares = 0;

    cv32e40p_tmr_spare_mgr #(.WIDTH(W), .THRESHOLD(T), .CNT_W(C)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_i        (valid),
        .clear_i        (clear),
        .rep0_i         (r0),
        .rep1_i         (r1),
        .rep2_i         (r2),
        .spare_i        (sp),
        .data_o         (data),
        .error_o        (error),
        .mismatch_o     (mismatch),
        .uncorr_o       (uncorr),
        .faulty_o       (faulty),
        .spare_active_o (spare_active),
        .spare_slot_o   (spare_slot),
        .fatal_o        (fatal)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance n clock edges, land 2 time units after the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_reps(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] s);
        r0 = a; r1 = b; r2 = c; sp = s;
        #1;
    endtask

    initial begin
        // reset: identity mapping, voter live during reset
        rst = 1'b1; valid = 1'b0; clear = 1'b0;
        set_reps(32'h5, 32'h5, 32'h7, 32'h0);
        chk("rst_data", data, 32'h5);
        chk("rst_mismatch", {29'd0, mismatch}, 32'h4);
        chk("rst_faulty", {29'd0, faulty}, 32'h0);
        chk("rst_spare_active", {31'd0, spare_active}, 32'h0);
        chk("rst_spare_slot", {30'd0, spare_slot}, 32'h0);
        chk("rst_fatal", {31'd0, fatal}, 32'h0);
        #20;
        rst = 1'b0;
        tick(1);

        // all agree for 10 valid cycles
        valid = 1'b1;
        set_reps(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tick(10);
        chk("t1_data", data, 32'hA5A5A5A5);
        chk("t1_error", {31'd0, error}, 32'h0);
        chk("t1_faulty", {29'd0, faulty}, 32'h0);
        chk("t1_cnt0", {24'd0, dut.cnt_q[0]}, 32'h0);
        chk("t1_cnt1", {24'd0, dut.cnt_q[1]}, 32'h0);
        chk("t1_cnt2", {24'd0, dut.cnt_q[2]}, 32'h0);

        // all pairwise different: uncorrectable, nothing counted
        set_reps(32'h1, 32'h2, 32'h4, 32'h0);
        chk("t4_uncorr", {31'd0, uncorr}, 32'h1);
        chk("t4_data", data, 32'h0);
        chk("t4_mismatch", {29'd0, mismatch}, 32'h7);
        tick(2);
        chk("t4_cnt0", {24'd0, dut.cnt_q[0]}, 32'h0);
        chk("t4_cnt1", {24'd0, dut.cnt_q[1]}, 32'h0);
        chk("t4_cnt2", {24'd0, dut.cnt_q[2]}, 32'h0);
        chk("t4_faulty", {29'd0, faulty}, 32'h0);

`ifdef CV32E40P_TMR_SPARE_EN
        // rep1 wrong three times: spared into slot 1
        set_reps(32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("t2_data", data, 32'hFFFFFFFF);
        chk("t2_mismatch", {29'd0, mismatch}, 32'h2);
        chk("t2_error", {31'd0, error}, 32'h1);
        tick(2);
        chk("t2_cnt1_mid", {24'd0, dut.cnt_q[1]}, 32'h2);
        chk("t2_spare_mid", {31'd0, spare_active}, 32'h0);
        tick(1);
        chk("t2_faulty", {29'd0, faulty}, 32'h2);
        chk("t2_spare_active", {31'd0, spare_active}, 32'h1);
        chk("t2_spare_slot", {30'd0, spare_slot}, 32'h1);
        chk("t2_cnt1_reset", {24'd0, dut.cnt_q[1]}, 32'h0);
        chk("t2_mismatch_after", {29'd0, mismatch}, 32'h0);
        chk("t2_fatal", {31'd0, fatal}, 32'h0);

        // spare wrong three times: degraded, counters frozen
        set_reps(32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0);
        chk("t3_mismatch", {29'd0, mismatch}, 32'h2);
        tick(2);
        chk("t3_fatal_mid", {31'd0, fatal}, 32'h0);
        tick(1);
        chk("t3_fatal", {31'd0, fatal}, 32'h1);
        chk("t3_cnt1", {24'd0, dut.cnt_q[1]}, 32'h3);
        chk("t3_faulty", {29'd0, faulty}, 32'h2);
        set_reps(32'h0, 32'h0, 32'hFFFFFFFF, 32'h0);
        chk("t3_mismatch_slot2", {29'd0, mismatch}, 32'h4);
        tick(2);
        chk("t3_cnt2_frozen", {24'd0, dut.cnt_q[2]}, 32'h0);
        chk("t3_cnt1_frozen", {24'd0, dut.cnt_q[1]}, 32'h3);
        chk("t3_map_frozen", {31'd0, spare_active}, 32'h1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        #1;
        chk("t3_clr_fatal", {31'd0, fatal}, 32'h0);
        chk("t3_clr_faulty", {29'd0, faulty}, 32'h0);
        chk("t3_clr_spare_active", {31'd0, spare_active}, 32'h0);
        chk("t3_clr_spare_slot", {30'd0, spare_slot}, 32'h0);
        chk("t3_clr_cnt1", {24'd0, dut.cnt_q[1]}, 32'h0);
        chk("t3_clr_identity", {29'd0, mismatch}, 32'h4);

        // reach SPARED, then async reset between clock edges
        set_reps(32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick(3);
        chk("t7_spared", {31'd0, spare_active}, 32'h1);
        rst = 1'b1;
        #1;
        chk("t7_spare_active", {31'd0, spare_active}, 32'h0);
        chk("t7_spare_slot", {30'd0, spare_slot}, 32'h0);
        chk("t7_faulty", {29'd0, faulty}, 32'h0);
        chk("t7_fatal", {31'd0, fatal}, 32'h0);
        chk("t7_identity", {29'd0, mismatch}, 32'h2);
        rst = 1'b0;
        tick(1);

        // rep0 and rep2 agree on a wrong value: vote flips, rep1 spared
        set_reps(32'h0BADBEEF, 32'hCAFEF00D, 32'h0BADBEEF, 32'hCAFEF00D);
        chk("t5_data", data, 32'h0BADBEEF);
        chk("t5_mismatch", {29'd0, mismatch}, 32'h2);
        tick(3);
        chk("t5_spare_active", {31'd0, spare_active}, 32'h1);
        chk("t5_spare_slot", {30'd0, spare_slot}, 32'h1);
        chk("t5_faulty", {29'd0, faulty}, 32'h2);
        set_reps(32'h0BADBEEF, 32'hCAFEF00D, 32'h0BADBEEF, 32'h0BADBEEF);
        chk("t5_mismatch_spare", {29'd0, mismatch}, 32'h0);
        chk("t5_data_spare", data, 32'h0BADBEEF);
        // a second replica fails while spared: degraded
        set_reps(32'h11111111, 32'hCAFEF00D, 32'h0BADBEEF, 32'h0BADBEEF);
        chk("t5_mismatch_rep0", {29'd0, mismatch}, 32'h1);
        tick(3);
        chk("t5_fatal", {31'd0, fatal}, 32'h1);
        chk("t5_faulty_deg", {29'd0, faulty}, 32'h3);
        chk("t5_data_deg", data, 32'h0BADBEEF);
`else
        // rep2 wrong three times: flagged, keeps voting, spare ignored
        set_reps(32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF);
        chk("t6_mismatch", {29'd0, mismatch}, 32'h4);
        chk("t6_data", data, 32'hA5A5A5A5);
        tick(3);
        chk("t6_faulty", {29'd0, faulty}, 32'h4);
        chk("t6_fatal", {31'd0, fatal}, 32'h0);
        chk("t6_spare_active", {31'd0, spare_active}, 32'h0);
        chk("t6_cnt2", {24'd0, dut.cnt_q[2]}, 32'h3);
        tick(1);
        chk("t6_cnt2_frozen", {24'd0, dut.cnt_q[2]}, 32'h3);
        chk("t6_mismatch_still", {29'd0, mismatch}, 32'h4);
        // rep0 wrong three times: second faulty slot -> degraded
        set_reps(32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hFFFFFFFF);
        chk("t6_mismatch_rep0", {29'd0, mismatch}, 32'h1);
        tick(2);
        chk("t6_fatal_mid", {31'd0, fatal}, 32'h0);
        tick(1);
        chk("t6_faulty2", {29'd0, faulty}, 32'h5);
        chk("t6_fatal2", {31'd0, fatal}, 32'h1);
        chk("t6_data_deg", data, 32'hA5A5A5A5);
`endif

        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        #1;
        chk("end_clr_fatal", {31'd0, fatal}, 32'h0);
        chk("end_clr_faulty", {29'd0, faulty}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
